// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ops, wakes operands off two CDBs, issues one op per cycle.
// Define RS_OLDEST_FIRST_EN for oldest-first select through an age matrix; default is lowest index.
module alu_reservation_station #(
    parameter int RS_SIZE       = 8,
    parameter int ROB_INDEX_BIT = 4,
    parameter int TYPE_BIT      = 5
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_in,
    input  logic                     issue_valid,
    input  logic [TYPE_BIT-1:0]      issue_type,
    input  logic [ROB_INDEX_BIT-1:0] issue_rob_id,
    input  logic [31:0]              issue_vj,
    input  logic [31:0]              issue_vk,
    input  logic                     issue_qj_valid,
    input  logic                     issue_qk_valid,
    input  logic [ROB_INDEX_BIT-1:0] issue_qj,
    input  logic [ROB_INDEX_BIT-1:0] issue_qk,
    output logic                     full,
    input  logic                     alu_cdb_valid,
    input  logic [ROB_INDEX_BIT-1:0] alu_cdb_rob_id,
    input  logic [31:0]              alu_cdb_value,
    input  logic                     lsb_cdb_valid,
    input  logic [ROB_INDEX_BIT-1:0] lsb_cdb_rob_id,
    input  logic [31:0]              lsb_cdb_value,
    output logic                     alu_req,
    output logic [TYPE_BIT-1:0]      alu_type,
    output logic [31:0]              alu_r1,
    output logic [31:0]              alu_r2,
    output logic [ROB_INDEX_BIT-1:0] alu_rob_id
);
    localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0]       busy, qjv, qkv, cand, beaten;
    logic [TYPE_BIT-1:0]      typ [RS_SIZE];
    logic [ROB_INDEX_BIT-1:0] rob [RS_SIZE];
    logic [ROB_INDEX_BIT-1:0] qj  [RS_SIZE];
    logic [ROB_INDEX_BIT-1:0] qk  [RS_SIZE];
    logic [31:0]              vj  [RS_SIZE];
    logic [31:0]              vk  [RS_SIZE];
    logic [IW-1:0]            free_idx, sel_idx;
    logic                     sel_ok, alloc;

    function automatic logic hit_alu(input logic [ROB_INDEX_BIT-1:0] tag);
        return alu_cdb_valid && (tag == alu_cdb_rob_id);
    endfunction

    function automatic logic hit_lsb(input logic [ROB_INDEX_BIT-1:0] tag);
        return lsb_cdb_valid && (tag == lsb_cdb_rob_id);
    endfunction

    assign full  = &busy;
    assign cand  = busy & ~qjv & ~qkv;
    assign alloc = issue_valid && !full;

    always_comb begin
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = i[IW-1:0];
        end
    end

    always_comb begin
        sel_ok  = 1'b0;
        sel_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (cand[i] && !beaten[i]) begin
                sel_ok  = 1'b1;
                sel_idx = i[IW-1:0];
            end
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    // older[i][j] set: entry j was allocated before entry i
    logic [RS_SIZE-1:0] older [RS_SIZE];
    logic [RS_SIZE-1:0] sel_mask;

    assign sel_mask = sel_ok ? (RS_SIZE'(1) << sel_idx) : '0;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) beaten[i] = |(cand & older[i]);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) older[i] <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                for (int i = 0; i < RS_SIZE; i++) older[i] <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) older[i] <= older[i] & ~sel_mask;
                if (alloc) older[free_idx] <= busy & ~sel_mask;
            end
        end
    end
`else
    assign beaten = '0;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy <= '0;
            qjv  <= '0;
            qkv  <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                typ[i] <= '0;
                rob[i] <= '0;
                qj[i]  <= '0;
                qk[i]  <= '0;
                vj[i]  <= '0;
                vk[i]  <= '0;
            end
            alu_req    <= 1'b0;
            alu_type   <= '0;
            alu_r1     <= '0;
            alu_r2     <= '0;
            alu_rob_id <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                busy    <= '0;
                alu_req <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && qjv[i]) begin
                        if (hit_alu(qj[i])) begin
                            vj[i]  <= alu_cdb_value;
                            qjv[i] <= 1'b0;
                        end else if (hit_lsb(qj[i])) begin
                            vj[i]  <= lsb_cdb_value;
                            qjv[i] <= 1'b0;
                        end
                    end
                    if (busy[i] && qkv[i]) begin
                        if (hit_alu(qk[i])) begin
                            vk[i]  <= alu_cdb_value;
                            qkv[i] <= 1'b0;
                        end else if (hit_lsb(qk[i])) begin
                            vk[i]  <= lsb_cdb_value;
                            qkv[i] <= 1'b0;
                        end
                    end
                end
                if (alloc) begin
                    busy[free_idx] <= 1'b1;
                    typ[free_idx]  <= issue_type;
                    rob[free_idx]  <= issue_rob_id;
                    qj[free_idx]   <= issue_qj;
                    qk[free_idx]   <= issue_qk;
                    vj[free_idx]   <= issue_vj;
                    vk[free_idx]   <= issue_vk;
                    qjv[free_idx]  <= issue_qj_valid;
                    qkv[free_idx]  <= issue_qk_valid;
                    if (issue_qj_valid && hit_alu(issue_qj)) begin
                        vj[free_idx]  <= alu_cdb_value;
                        qjv[free_idx] <= 1'b0;
                    end else if (issue_qj_valid && hit_lsb(issue_qj)) begin
                        vj[free_idx]  <= lsb_cdb_value;
                        qjv[free_idx] <= 1'b0;
                    end
                    if (issue_qk_valid && hit_alu(issue_qk)) begin
                        vk[free_idx]  <= alu_cdb_value;
                        qkv[free_idx] <= 1'b0;
                    end else if (issue_qk_valid && hit_lsb(issue_qk)) begin
                        vk[free_idx]  <= lsb_cdb_value;
                        qkv[free_idx] <= 1'b0;
                    end
                end
                alu_req <= sel_ok;
                if (sel_ok) begin
                    busy[sel_idx] <= 1'b0;
                    alu_type      <= typ[sel_idx];
                    alu_r1        <= vj[sel_idx];
                    alu_r2        <= vk[sel_idx];
                    alu_rob_id    <= rob[sel_idx];
                end
            end
        end
    end
endmodule
